// File: rtl/serial_divider.sv
// Bit-serial restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Shares the Start/Done/Busy handshake of the companion serial multiplier.
module serial_divider #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          Start,
   input  logic [DW-1:0] P,
   input  logic [VW-1:0] B,
   output logic [DW-1:0] Q,
   output logic [VW-1:0] R,
   output logic          Done,
   output logic          Busy,
   output logic          DivZero
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] dq_q, dq_d;      // dividend shifts out the top, quotient bits enter the bottom
   logic [VW-1:0] dvs_q, dvs_d;
   logic [VW-1:0] rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          zero_q, zero_d;
   logic [DW-1:0] q_q, q_d;
   logic [VW-1:0] r_q, r_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          dz_q, dz_d;

   logic [VW:0]   shifted;
   logic [VW+1:0] trial;
   logic          borrow;
   logic [VW:0]   rem_step;
   logic [DW-1:0] dq_step;

   // One restoring step; the extra top bit of trial is the borrow.
   always_comb begin
      shifted  = {rem_q, dq_q[DW-1]};
      trial    = {1'b0, shifted} - {2'b00, dvs_q};
      borrow   = trial[VW+1];
      rem_step = borrow ? shifted : trial[VW:0];
      dq_step  = {dq_q[DW-2:0], ~borrow};
   end

   always_comb begin
      state_d = state_q;
      dq_d    = dq_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      q_d     = q_q;
      r_d     = r_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               dq_d    = P;
               dvs_d   = B;
               rem_d   = '0;
               cnt_d   = CW'(DW);
               zero_d  = (B == '0);
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (zero_q) begin
               // Divide-by-zero spends its single busy cycle here without touching the datapath.
               q_d     = '1;
               r_d     = '0;
               dz_d    = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               zero_d  = 1'b0;
               state_d = FIN;
            end else begin
               dq_d  = dq_step;
               rem_d = rem_step[VW-1:0];
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  q_d     = dq_step;
                  r_d     = rem_step[VW-1:0];
                  dz_d    = 1'b0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = FIN;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dq_q    <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dq_q    <= dq_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         q_q     <= q_d;
         r_q     <= r_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         dz_q    <= dz_d;
      end
   end

   assign Q       = q_q;
   assign R       = r_q;
   assign Done    = done_q;
   assign Busy    = busy_q;
   assign DivZero = dz_q;

endmodule

// File: tb/tb_serial_divider.sv
// Directed bench for serial_divider: vector table, handshake corner cases and
// exhaustive round-trip against a reference / and % model.
module tb_serial_divider;

   logic       clk;
   logic       rst_n;
   logic       Start;
   logic [7:0] P;
   logic [3:0] B;
   logic [7:0] Q;
   logic [3:0] R;
   logic       Done;
   logic       Busy;
   logic       DivZero;

   int n_cmp = 0;
   int n_bad = 0;

   serial_divider dut (
      .clk(clk), .rst_n(rst_n), .Start(Start), .P(P), .B(B),
      .Q(Q), .R(R), .Done(Done), .Busy(Busy), .DivZero(DivZero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] p;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
      int         lat;
   } vec_t;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One division: Start for one cycle, then watch for Done within a bounded window.
   task automatic run_div(input logic [7:0] p, input logic [3:0] b, input logic [7:0] eq,
                          input logic [3:0] er, input logic edz, input int elat, input bit verbose);
      int lat;
      bit seen;
      @(negedge clk);
      Start = 1'b1; P = p; B = b;
      @(posedge clk); #1;
      check(Busy == 1'b1, "busy_on_accept", Busy, 1);
      Start = 1'b0; P = ~p; B = ~b;
      lat = 0; seen = 1'b0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(posedge clk); #1;
         if (Done) begin
            seen = 1'b1;
            lat  = i;
         end else begin
            check(Busy == 1'b1, "busy_during_calc", Busy, 1);
         end
      end
      check(seen && lat == elat, "done_latency", seen ? lat : -1, elat);
      check(Busy == 1'b0, "busy_with_done", Busy, 0);
      check(Q == eq, "quotient", Q, eq);
      check(R == er, "remainder", R, er);
      check(DivZero == edz, "divzero", DivZero, edz);
      @(posedge clk); #1;
      check(Done == 1'b0, "done_one_cycle", Done, 0);
      if (verbose)
         $display("div P=%0d B=%0d -> Q=%0d R=%0d DivZero=%0d latency=%0d", p, b, Q, R, DivZero, lat);
   endtask

   vec_t vecs[10];
   int   done_seen;

   initial begin
      vecs[0] = '{8'd130, 4'd13, 8'd10,  4'd0,  1'b0, 8};
      vecs[1] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 8};
      vecs[2] = '{8'd9,   4'd13, 8'd0,   4'd9,  1'b0, 8};
      vecs[3] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 8};
      vecs[4] = '{8'd77,  4'd0,  8'd255, 4'd0,  1'b1, 1};
      vecs[5] = '{8'd100, 4'd3,  8'd33,  4'd1,  1'b0, 8};
      vecs[6] = '{8'd143, 4'd11, 8'd13,  4'd0,  1'b0, 8};
      vecs[7] = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 8};
      vecs[8] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 8};
      vecs[9] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 8};

      rst_n = 1'b0; Start = 1'b0; P = '0; B = '0;
      repeat (3) @(posedge clk);
      #1;
      check(Q == 8'd0, "reset_q", Q, 0);
      check(R == 4'd0, "reset_r", R, 0);
      check(Done == 1'b0, "reset_done", Done, 0);
      check(Busy == 1'b0, "reset_busy", Busy, 0);
      check(DivZero == 1'b0, "reset_divzero", DivZero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i])
         run_div(vecs[i].p, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, 1'b1);

      // Start held high; P/B corrupted mid-CALC and restored before each accept.
      for (int e = 0; e <= 35; e++) begin
         @(negedge clk);
         Start = (e <= 29);
         if (e % 10 >= 3 && e % 10 <= 6) begin
            P = 8'hAA; B = 4'h5;
         end else begin
            P = 8'd143; B = 4'd11;
         end
         @(posedge clk); #1;
         if (e == 0) check(Busy == 1'b1, "b2b_busy_accept", Busy, 1);
         if (e >= 1) begin
            check(Done == (e % 10 == 8), "b2b_done_timing", Done, (e % 10 == 8));
            check(!(Done && Busy), "b2b_busy_done_overlap", Busy, 0);
            if (Done) begin
               check(Q == 8'd13, "b2b_quotient", Q, 13);
               check(R == 4'd0, "b2b_remainder", R, 0);
               $display("b2b P=143 B=11 -> Q=%0d R=%0d at cycle %0d", Q, R, e);
            end
         end
      end
      Start = 1'b0;

      // Asynchronous abort mid-CALC.
      @(negedge clk);
      Start = 1'b1; P = 8'd200; B = 4'd7;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check(Q == 8'd0, "abort_q", Q, 0);
      check(R == 4'd0, "abort_r", R, 0);
      check(Busy == 1'b0, "abort_busy", Busy, 0);
      check(Done == 1'b0, "abort_done", Done, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (Done) done_seen++;
      end
      check(done_seen == 0, "abort_no_done", done_seen, 0);
      $display("abort during CALC -> outputs cleared, no Done");
      run_div(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 8, 1'b1);

      // Multiply-then-divide round-trip.
      for (int a = 0; a < 16; a++)
         for (int b = 1; b < 16; b++)
            run_div(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0, 8, 1'b0);
      $display("round-trip A*B/B sweep complete");

      // Every dividend against the reference model.
      for (int p = 0; p < 256; p++)
         for (int b = 1; b < 16; b++)
            run_div(8'(p), 4'(b), 8'(p / b), 4'(p % b), 1'b0, 8, 1'b0);
      $display("full dividend sweep complete");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
